// File: rtl/instruction_fetch_unit_pkg.sv
// Shared opcode and fetch-unit definitions for the MIPS-style pipeline.
// Opcode field occupies [OPC_HI:OPC_LO]; operand field is the low ADDR_W bits.
package instruction_fetch_unit_pkg;

   localparam int OPC_HI = 15;
   localparam int OPC_LO = 10;
   localparam int OPC_W  = OPC_HI - OPC_LO + 1;

   localparam logic [OPC_W-1:0] OP_NOP  = 6'b000000;
   localparam logic [OPC_W-1:0] OP_JMP  = 6'b000001;
   localparam logic [OPC_W-1:0] OP_BANE = 6'b000100;
   localparam logic [OPC_W-1:0] OP_BACC = 6'b000101;
   localparam logic [OPC_W-1:0] OP_BBNE = 6'b000110;
   localparam logic [OPC_W-1:0] OP_BBCC = 6'b000111;
   localparam logic [OPC_W-1:0] OP_BBPL = 6'b001000;

   typedef enum logic [1:0] {
      IFU_BOOT   = 2'd0,
      IFU_RUN    = 2'd1,
      IFU_HALTED = 2'd2
   } ifu_state_e;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Front-end fetch sequencer: PC, ROM addressing and the IF/ID register.
// Optional macro IFU_EARLY_JMP_EN resolves JMP in fetch instead of downstream.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = 10,
   parameter int                INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               Clock,
   input  logic               Reset,
   output logic [ADDR_W-1:0]  oIromAddress,
   input  logic [INSTR_W-1:0] iIromInstruction,
   input  logic               iStall,
   input  logic               iRedirect,
   input  logic [ADDR_W-1:0]  iRedirectTarget,
   input  logic               iHalt,
   output logic [INSTR_W-1:0] oInstruction,
   output logic [ADDR_W-1:0]  oPcPlus1,
   output logic               oValid,
   output logic [1:0]         oState
);

   localparam logic [INSTR_W-1:0] NOP_INSTR = {(INSTR_W-ADDR_W)'(OP_NOP), {ADDR_W{1'b0}}};

   ifu_state_e         state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d, pc_inc;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  pcp1_q, pcp1_d;
   logic               valid_q, valid_d;

   assign pc_inc       = pc_q + 1'b1;
   assign oIromAddress = pc_q;
   assign oInstruction = instr_q;
   assign oPcPlus1     = pcp1_q;
   assign oValid       = valid_q;
   assign oState       = state_q;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= IFU_BOOT;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         pcp1_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pcp1_q  <= pcp1_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pcp1_d  = pcp1_q;
      valid_d = valid_q;
      case (state_q)
         IFU_BOOT: begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            state_d = IFU_RUN;
         end
         IFU_RUN: begin
            if (iRedirect) begin
               pc_d    = iRedirectTarget;
               instr_d = NOP_INSTR;
               valid_d = 1'b0;
            end else if (iHalt) begin
               instr_d = NOP_INSTR;
               valid_d = 1'b0;
               state_d = IFU_HALTED;
            end else if (!iStall) begin
`ifdef IFU_EARLY_JMP_EN
               // JMP is consumed here as a bubble; branches still go downstream
               if (iIromInstruction[INSTR_W-1:ADDR_W] == (INSTR_W-ADDR_W)'(OP_JMP)) begin
                  pc_d    = iIromInstruction[ADDR_W-1:0];
                  instr_d = NOP_INSTR;
                  valid_d = 1'b0;
               end else begin
                  pc_d    = pc_inc;
                  instr_d = iIromInstruction;
                  pcp1_d  = pc_inc;
                  valid_d = 1'b1;
               end
`else
               pc_d    = pc_inc;
               instr_d = iIromInstruction;
               pcp1_d  = pc_inc;
               valid_d = 1'b1;
`endif
            end
         end
         IFU_HALTED: begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            if (iRedirect) begin
               pc_d    = iRedirectTarget;
               state_d = IFU_RUN;
            end
         end
         default: begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            state_d = IFU_BOOT;
         end
      endcase
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural ROM model.
module tb_instruction_fetch_unit;
   import instruction_fetch_unit_pkg::*;

   logic        Clock;
   logic        Reset;
   logic [9:0]  oIromAddress;
   logic [15:0] iIromInstruction;
   logic        iStall;
   logic        iRedirect;
   logic [9:0]  iRedirectTarget;
   logic        iHalt;
   logic [15:0] oInstruction;
   logic [9:0]  oPcPlus1;
   logic        oValid;
   logic [1:0]  oState;

   int compared   = 0;
   int mismatched = 0;

   localparam logic [15:0] NOP_W = 16'h0000;

   instruction_fetch_unit #(.ADDR_W(10), .INSTR_W(16), .RESET_PC(10'd0)) dut (
      .Clock(Clock), .Reset(Reset), .oIromAddress(oIromAddress),
      .iIromInstruction(iIromInstruction), .iStall(iStall), .iRedirect(iRedirect),
      .iRedirectTarget(iRedirectTarget), .iHalt(iHalt), .oInstruction(oInstruction),
      .oPcPlus1(oPcPlus1), .oValid(oValid), .oState(oState)
   );

   // Word 5 is a JMP to 0; every other word has opcode 11xxxx and operand ~addr.
   function automatic logic [15:0] rom_word(input logic [9:0] a);
      if (a == 10'd5) return {OP_JMP, 10'd0};
      return {2'b11, a[3:0], ~a};
   endfunction

   assign iIromInstruction = rom_word(oIromAddress);

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b0; iStall = 0; iRedirect = 0; iRedirectTarget = '0; iHalt = 0;
      #3;
      compared++; if (oIromAddress !== 10'd0) begin mismatched++; $display("FAIL rst_pc: got %0d want 0", oIromAddress); end
      compared++; if (oInstruction !== NOP_W) begin mismatched++; $display("FAIL rst_instr: got %h want %h", oInstruction, NOP_W); end
      compared++; if (oPcPlus1 !== 10'd0) begin mismatched++; $display("FAIL rst_pcp1: got %0d want 0", oPcPlus1); end
      compared++; if (oValid !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %0b want 0", oValid); end
      compared++; if (oState !== 2'd0) begin mismatched++; $display("FAIL rst_state: got %0d want 0", oState); end
      @(negedge Clock);
      Reset = 1'b1;
      tick();
      compared++; if (oState !== 2'd1) begin mismatched++; $display("FAIL boot_state: got %0d want 1", oState); end
      compared++; if (oValid !== 1'b0) begin mismatched++; $display("FAIL boot_valid: got %0b want 0", oValid); end
      compared++; if (oIromAddress !== 10'd0) begin mismatched++; $display("FAIL boot_pc: got %0d want 0", oIromAddress); end
      for (int unsigned i = 0; i < 3; i++) begin
         tick();
         compared++; if (oInstruction !== rom_word(10'(i))) begin mismatched++; $display("FAIL fetch%0d_instr: got %h want %h", i, oInstruction, rom_word(10'(i))); end
         compared++; if (oPcPlus1 !== 10'(i + 1)) begin mismatched++; $display("FAIL fetch%0d_pcp1: got %0d want %0d", i, oPcPlus1, i + 1); end
         compared++; if (oValid !== 1'b1) begin mismatched++; $display("FAIL fetch%0d_valid: got %0b want 1", i, oValid); end
      end
   endtask

   task automatic test_stall();
      tick();
      compared++; if (oIromAddress !== 10'd4) begin mismatched++; $display("FAIL pre_stall_pc: got %0d want 4", oIromAddress); end
      iStall = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
         tick();
         compared++; if (oInstruction !== rom_word(10'd3)) begin mismatched++; $display("FAIL stall%0d_instr: got %h want %h", i, oInstruction, rom_word(10'd3)); end
         compared++; if (oPcPlus1 !== 10'd4) begin mismatched++; $display("FAIL stall%0d_pcp1: got %0d want 4", i, oPcPlus1); end
         compared++; if (oIromAddress !== 10'd4) begin mismatched++; $display("FAIL stall%0d_pc: got %0d want 4", i, oIromAddress); end
         compared++; if (oValid !== 1'b1) begin mismatched++; $display("FAIL stall%0d_valid: got %0b want 1", i, oValid); end
      end
      iStall = 1'b0;
      tick();
      compared++; if (oInstruction !== rom_word(10'd4)) begin mismatched++; $display("FAIL unstall_instr: got %h want %h", oInstruction, rom_word(10'd4)); end
      compared++; if (oPcPlus1 !== 10'd5) begin mismatched++; $display("FAIL unstall_pcp1: got %0d want 5", oPcPlus1); end
   endtask

   task automatic test_redirect_stall();
      iRedirect = 1'b1; iRedirectTarget = 10'd9; iStall = 1'b1;
      tick();
      iRedirect = 1'b0; iStall = 1'b0;
      compared++; if (oValid !== 1'b0) begin mismatched++; $display("FAIL redir_valid: got %0b want 0", oValid); end
      compared++; if (oInstruction !== NOP_W) begin mismatched++; $display("FAIL redir_instr: got %h want %h", oInstruction, NOP_W); end
      compared++; if (oIromAddress !== 10'd9) begin mismatched++; $display("FAIL redir_pc: got %0d want 9", oIromAddress); end
      tick();
      compared++; if (oInstruction !== rom_word(10'd9)) begin mismatched++; $display("FAIL redir_fetch_instr: got %h want %h", oInstruction, rom_word(10'd9)); end
      compared++; if (oPcPlus1 !== 10'd10) begin mismatched++; $display("FAIL redir_fetch_pcp1: got %0d want 10", oPcPlus1); end
      compared++; if (oValid !== 1'b1) begin mismatched++; $display("FAIL redir_fetch_valid: got %0b want 1", oValid); end
   endtask

   task automatic test_wrap();
      iRedirect = 1'b1; iRedirectTarget = 10'd1023;
      tick();
      iRedirect = 1'b0;
      tick();
      compared++; if (oInstruction !== rom_word(10'd1023)) begin mismatched++; $display("FAIL wrap_instr: got %h want %h", oInstruction, rom_word(10'd1023)); end
      compared++; if (oPcPlus1 !== 10'd0) begin mismatched++; $display("FAIL wrap_pcp1: got %0d want 0", oPcPlus1); end
      compared++; if (oIromAddress !== 10'd0) begin mismatched++; $display("FAIL wrap_pc: got %0d want 0", oIromAddress); end
      tick();
      compared++; if (oInstruction !== rom_word(10'd0)) begin mismatched++; $display("FAIL wrap_next_instr: got %h want %h", oInstruction, rom_word(10'd0)); end
      compared++; if (oPcPlus1 !== 10'd1) begin mismatched++; $display("FAIL wrap_next_pcp1: got %0d want 1", oPcPlus1); end
   endtask

   task automatic test_halt();
      iHalt = 1'b1;
      tick();
      compared++; if (oState !== 2'd2) begin mismatched++; $display("FAIL halt_state: got %0d want 2", oState); end
      for (int unsigned i = 0; i < 5; i++) begin
         iStall = i[0];
         iHalt  = i[1];
         tick();
         compared++; if (oValid !== 1'b0) begin mismatched++; $display("FAIL halted%0d_valid: got %0b want 0", i, oValid); end
         compared++; if (oIromAddress !== 10'd1) begin mismatched++; $display("FAIL halted%0d_pc: got %0d want 1", i, oIromAddress); end
         compared++; if (oState !== 2'd2) begin mismatched++; $display("FAIL halted%0d_state: got %0d want 2", i, oState); end
      end
      iStall = 1'b0; iHalt = 1'b0; iRedirect = 1'b1; iRedirectTarget = 10'd2;
      tick();
      iRedirect = 1'b0;
      compared++; if (oState !== 2'd1) begin mismatched++; $display("FAIL resume_state: got %0d want 1", oState); end
      compared++; if (oValid !== 1'b0) begin mismatched++; $display("FAIL resume_valid: got %0b want 0", oValid); end
      compared++; if (oIromAddress !== 10'd2) begin mismatched++; $display("FAIL resume_pc: got %0d want 2", oIromAddress); end
      tick();
      compared++; if (oInstruction !== rom_word(10'd2)) begin mismatched++; $display("FAIL resume_instr: got %h want %h", oInstruction, rom_word(10'd2)); end
      compared++; if (oValid !== 1'b1) begin mismatched++; $display("FAIL resume_fetch_valid: got %0b want 1", oValid); end
      compared++; if (oPcPlus1 !== 10'd3) begin mismatched++; $display("FAIL resume_pcp1: got %0d want 3", oPcPlus1); end
   endtask

   task automatic test_jmp();
      iRedirect = 1'b1; iRedirectTarget = 10'd4;
      tick();
      iRedirect = 1'b0;
      tick();
      compared++; if (oIromAddress !== 10'd5) begin mismatched++; $display("FAIL jmp_pre_pc: got %0d want 5", oIromAddress); end
      tick();
`ifdef IFU_EARLY_JMP_EN
      compared++; if (oValid !== 1'b0) begin mismatched++; $display("FAIL jmp_valid: got %0b want 0", oValid); end
      compared++; if (oInstruction !== NOP_W) begin mismatched++; $display("FAIL jmp_instr: got %h want %h", oInstruction, NOP_W); end
      compared++; if (oIromAddress !== 10'd0) begin mismatched++; $display("FAIL jmp_pc: got %0d want 0", oIromAddress); end
`else
      compared++; if (oValid !== 1'b1) begin mismatched++; $display("FAIL jmp_valid: got %0b want 1", oValid); end
      compared++; if (oInstruction !== rom_word(10'd5)) begin mismatched++; $display("FAIL jmp_instr: got %h want %h", oInstruction, rom_word(10'd5)); end
      compared++; if (oPcPlus1 !== 10'd6) begin mismatched++; $display("FAIL jmp_pcp1: got %0d want 6", oPcPlus1); end
      compared++; if (oIromAddress !== 10'd6) begin mismatched++; $display("FAIL jmp_pc: got %0d want 6", oIromAddress); end
`endif
   endtask

   task automatic test_reset_pulse();
      tick();
      tick();
      #2;
      Reset = 1'b0;
      #1;
      compared++; if (oIromAddress !== 10'd0) begin mismatched++; $display("FAIL arst_pc: got %0d want 0", oIromAddress); end
      compared++; if (oInstruction !== NOP_W) begin mismatched++; $display("FAIL arst_instr: got %h want %h", oInstruction, NOP_W); end
      compared++; if (oPcPlus1 !== 10'd0) begin mismatched++; $display("FAIL arst_pcp1: got %0d want 0", oPcPlus1); end
      compared++; if (oValid !== 1'b0) begin mismatched++; $display("FAIL arst_valid: got %0b want 0", oValid); end
      compared++; if (oState !== 2'd0) begin mismatched++; $display("FAIL arst_state: got %0d want 0", oState); end
      @(negedge Clock);
      Reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_stall();
      test_redirect_stall();
      test_wrap();
      test_halt();
      test_jmp();
      test_reset_pulse();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front-end sequencer for the combinational 1024x16 instruction ROM.
- Owns the 10-bit program counter, drives the ROM address and captures the ROM output into the IF/ID pipeline register.
- Handles stall, flush/redirect from the branch-resolve stage, and halt.
- Sits between instruction_rom and the decode stage of the MIPS-style pipeline.

Parameters:
- RESET_PC, 10'd0, PC value loaded on reset.
- ADDR_W, 10, PC/ROM address width; also the operand-field width.
- INSTR_W, 16, instruction width; opcode is [INSTR_W-1:ADDR_W].

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- oIromAddress  output  ADDR_W  ROM address; combinationally equal to PC.
- iIromInstruction  input  INSTR_W  ROM data; combinational from oIromAddress.
- iStall  input  1  decode hazard; hold PC and IF/ID.
- iRedirect  input  1  branch/jump taken, resolved downstream.
- iRedirectTarget  input  ADDR_W  new PC when iRedirect=1.
- iHalt  input  1  stop fetching after the current cycle.
- oInstruction  output  INSTR_W  IF/ID instruction.
- oPcPlus1  output  ADDR_W  IF/ID PC of fetched instruction + 1.
- oValid  output  1  IF/ID holds a real instruction.
- oState  output  2  FSM state, for debug.

Behaviour:
Reset (Reset=0, asynchronous):
- PC=RESET_PC, oInstruction={`NOP,10'd0}, oPcPlus1=0, oValid=0, state=BOOT.
- Reset asserted mid-operation discards everything in-flight immediately.

FSM encoding in the definitions include: BOOT=0, RUN=1, HALTED=2; 3 is illegal and recovers to BOOT.
- BOOT: one bubble cycle; IF/ID loads NOP with oValid=0; PC is held; next state RUN.
- RUN: priority per clock edge is iRedirect > iHalt > iStall > normal fetch.
  - iRedirect: PC<=iRedirectTarget; IF/ID<=NOP, oValid=0 (flush); stays RUN. Overrides a simultaneous iStall or iHalt.
  - iHalt: PC held; IF/ID<=NOP, oValid=0; next HALTED.
  - iStall: PC, oInstruction, oPcPlus1 and oValid all hold.
  - normal: oInstruction<=iIromInstruction; oPcPlus1<=PC+1; oValid<=1; PC<=PC+1.
- HALTED: PC held; IF/ID is NOP with oValid=0. iStall is ignored.
  - iRedirect: PC<=target, next RUN. The first real fetch occurs on the following edge.
  - iHalt while already HALTED has no effect.

Arithmetic and latency:
- PC+1 is modulo 2^ADDR_W: 1023 wraps to 0. oPcPlus1 wraps identically.
- Fetch latency: one cycle from PC to a valid IF/ID entry.
- Redirect penalty: one bubble cycle.
- Throughput: one instruction per clock when unstalled.

Optional Feature:
- Macro: IFU_EARLY_JMP_EN.
- Enabled: in RUN with no iRedirect, iHalt or iStall, when iIromInstruction[15:10]==`JMP:
  - PC<=iIromInstruction[9:0];
  - IF/ID<=NOP with oValid=0, so the JMP never reaches later stages;
  - cost is one bubble; the downstream redirect is not needed for JMP.
- Disabled: JMP is fetched as a normal instruction; the downstream stage resolves it via iRedirect.
- Branch opcodes (BANE, BACC, BBNE, BBCC, BBPL) are always treated as normal fetches.

Decomposition:
- Shared definitions include (the existing opcode definitions file) holds:
  - opcode macros (`NOP, `JMP, branches);
  - opcode field bounds;
  - new IFU state constants IFU_BOOT, IFU_RUN, IFU_HALTED.
- Single module, no sub-module. The PC register and IF/ID register stay inline.
- The top level instantiates instruction_rom next to this block.

Test Plan:
- Reset release -> cycle 1: oValid=0, state BOOT; cycle 2 RUN; from cycle 3, oInstruction tracks ROM words 0,1,2 with oPcPlus1=1,2,3 and oValid=1.
- Stall 3 cycles at PC=4 -> oInstruction holds word 3 and oPcPlus1=4; PC stays 4; after release, word 4 appears next with oPcPlus1=5.
- iRedirect=1 with target=9, together with iStall=1 -> next edge oValid=0, PC=9; the following edge loads word 9 with oPcPlus1=10.
- Force PC=1023 via redirect -> fetch word 1023 with oPcPlus1=0, then PC=0; the next fetch is word 0.
- Halt sequence:
  - iHalt in RUN -> HALTED; oValid=0 for 5 cycles with the PC frozen.
  - iRedirect to target 2 -> RUN; word 2 fetched one cycle later.
  - Reset pulse mid-run -> all outputs return to reset values asynchronously.
- IFU_EARLY_JMP_EN with ROM word 5={`JMP,10'd0} -> after word 5 is fetched: oValid=0 and PC=0, with no iRedirect. Without the macro: word 5 is passed with oValid=1 and PC=6.
